fpu_sequencer: RTL and testbench
================================

# fpu_sequencer

Issues one floating-point request at a time from the integer core's execute stage to `fpu_controller` and returns a single-cycle result pulse. It drives the controller's op select, operands and stb/ack handshakes, and evaluates feq/flt/fle locally because the controller has no compare datapath. Illegal op codes are flagged without touching the FPU.

## Interface

- No parameters.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. The same `rst` drives the FPU cores.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle; a request is accepted when `req_valid && req_ready`.
- `req_op` in 4: op code. 0000 fadd, 0001 fsub, 0010 fmul, 0011 fdiv, 0100 fcvt.s.w, 0101 fcvt.w.s, 0110 feq, 0111 flt, 1000 fle; 1001–1111 illegal.
- `req_rs1`, `req_rs2` in 32: operands (raw bits).
- `resp_valid` out 1: one-cycle result pulse.
- `resp_data` out 32: result, held until the next response.
- `resp_err` out 1: illegal op; qualified by `resp_valid`.
- `fpu_op` out 4: op to the controller.
- `fpu_in1`, `fpu_in2` out 32: operands to the controller.
- `fpu_in_stb` out 1: operand strobe (connects to the controller's `in1_stb`; `in2_stb` is tied to it).
- `fpu_in1_ack`, `fpu_in2_ack` in 1: operand acks.
- `fpu_out` in 32: FPU result.
- `fpu_out_stb` in 1: FPU result valid.
- `fpu_out_ack` out 1: result accepted.

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready=1`, `fpu_op=4'b1111` (deselects every core), all strobes and acks 0.
  - On accept, latch op, rs1 and rs2.
  - FPU op (0000–0101): go to ISSUE.
  - Compare op (0110–1000): compute the result from the request inputs, register it into `resp_data`, go to RESP.
  - Illegal op: `resp_data` ← 0, `resp_err` ← 1, go to RESP.
- ISSUE:
  - `fpu_op` = latched op; `fpu_in1`/`fpu_in2` = latched operands; `fpu_in_stb=1`.
  - Set sticky flag `a_done` on a cycle with `fpu_in1_ack`.
  - Leave for WAIT on the first cycle where `fpu_in2_ack && (a_done || fpu_in1_ack)`. For unary ops the controller mirrors in1_ack onto in2_ack, so one ack cycle suffices.
  - `fpu_in_stb` drops in WAIT.
- WAIT:
  - `fpu_op` held; `fpu_out_ack=1` throughout.
  - On a cycle with `fpu_out_stb=1`: handshake completes that cycle, latch `fpu_out` into `resp_data`, clear `resp_err`, go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE. `req_ready=0` in RESP.
- `fpu_op`, `fpu_in1` and `fpu_in2` are stable from ISSUE entry until RESP.
- Compare rules (32-bit; a = rs1, b = rs2):
  - NaN means exponent = 8'hFF and mantissa ≠ 0.
  - Zeros are equal regardless of sign.
  - Either operand NaN → result 0 for all three ops.
  - feq: bits equal, or both zero.
  - flt: sign-magnitude ordering. Signs differ → a negative and not both zero. Both positive → a[30:0] < b[30:0]. Both negative → a[30:0] > b[30:0].
  - fle: flt or feq.
  - Result is 32'h1 or 32'h0.
- No fflags, no rounding-mode input; FPU rounding is whatever the cores implement.

## Timing

- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_data=0`, `resp_err=0`, `fpu_op=4'b1111`, `fpu_in1=fpu_in2=0`, `fpu_in_stb=0`, `fpu_out_ack=0`, `a_done=0`.
- Compare or illegal op: accepted in cycle 0, `resp_valid` in cycle 1, `req_ready` back in cycle 2.
- FPU op: accepted in cycle 0, stb from cycle 1. `resp_valid` comes one cycle after the `fpu_out_stb` cycle. There is no timeout.
- Back-to-back requests: a new accept is possible no earlier than the cycle after RESP.
- Requests presented while `req_ready=0` are ignored; the requester holds them.
- `rst` asserted in any state returns to IDLE next cycle with reset values, aborting the transaction with no response. FPU cores reset on the same edge.
- An FPU ack or `fpu_out_stb` arriving in IDLE or RESP is ignored.

## Test plan

- fadd: rs1=0x3F800000, rs2=0x40000000 → `resp_data=0x40400000`, `resp_err=0`, exactly one `resp_valid` pulse. `fpu_in_stb` drops after the in2_ack cycle; `fpu_op` is stable through WAIT.
- fsub then fcvt.s.w back-to-back (requester holds `req_valid`):
  - fsub 0x40400000 − 0x3F800000 → 0x40000000.
  - fcvt.s.w rs1=7 → 0x40E00000.
  - The second request is accepted only after the first RESP.
- Compares, each with 1-cycle latency and `fpu_op` staying 1111:
  - feq(0x7FC00000, 0x7FC00000) → 0.
  - feq(0x80000000, 0x00000000) → 1.
  - flt(-0, +0) → 0; fle(-0, +0) → 1.
  - flt(0xBF800000, 0x40000000) → 1.
- Illegal op 1010 → `resp_err=1`, `resp_data=0`, next cycle; no FPU strobe ever asserted.
- fdiv 0x40E00000/0x40000000 with `rst` pulsed during WAIT → no `resp_valid`, outputs at reset values. A following fmul 0x40000000×0x40400000 → 0x40C00000.

Source files
------------

// File: rtl/fpu_sequencer.sv
// fpu_sequencer
//   Sends one floating-point request at a time from the integer execute stage
//   to fpu_controller and returns a single-cycle result pulse. feq/flt/fle are
//   evaluated locally because the controller has no compare datapath. Illegal
//   op codes are answered with an error and never reach the FPU.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake (accept = valid && ready)
//   req_op_i, req_rs1_i/rs2_i     op code and raw operand bits
//   resp_valid_o                  one-cycle result pulse
//   resp_data_o, resp_err_o       result (held) and illegal-op flag
//   fpu_op_o, fpu_in1_o/in2_o     op select and operands to the controller
//   fpu_in_stb_o                  operand strobe (in1_stb and in2_stb)
//   fpu_in1_ack_i, fpu_in2_ack_i  operand acks from the controller
//   fpu_out_i, fpu_out_stb_i      FPU result and its strobe
//   fpu_out_ack_o                 result accepted
module fpu_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic [3:0]  fpu_op_o,
  output logic [31:0] fpu_in1_o,
  output logic [31:0] fpu_in2_o,
  output logic        fpu_in_stb_o,
  input  logic        fpu_in1_ack_i,
  input  logic        fpu_in2_ack_i,
  input  logic [31:0] fpu_out_i,
  input  logic        fpu_out_stb_i,
  output logic        fpu_out_ack_o
);

  localparam logic [3:0] OP_LAST_FPU = 4'b0101;
  localparam logic [3:0] OP_FEQ      = 4'b0110;
  localparam logic [3:0] OP_FLT      = 4'b0111;
  localparam logic [3:0] OP_FLE      = 4'b1000;
  localparam logic [3:0] OP_NONE     = 4'b1111;  // deselects every FPU core

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Single-precision compare; any NaN operand yields 0, signed zeros are equal.
  function automatic logic [31:0] fcmp(input logic [3:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic        any_nan;
    logic        both_zero;
    logic        eq;
    logic        lt;
    logic [31:0] res;
    any_nan   = is_nan(a) || is_nan(b);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    eq        = !any_nan && ((a == b) || both_zero);
    if (any_nan) begin
      lt = 1'b0;
    end else if (a[31] != b[31]) begin
      lt = a[31] && !both_zero;
    end else if (!a[31]) begin
      lt = a[30:0] < b[30:0];
    end else begin
      // both negative: larger magnitude is the smaller value
      lt = a[30:0] > b[30:0];
    end
    case (op)
      OP_FEQ:  res = {31'd0, eq};
      OP_FLT:  res = {31'd0, lt};
      OP_FLE:  res = {31'd0, lt | eq};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  fpu_op_q, fpu_op_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic        in_stb_q, in_stb_d;
  logic        out_ack_q, out_ack_d;
  logic        a_done_q, a_done_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    fpu_op_d     = fpu_op_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    in_stb_d     = in_stb_q;
    out_ack_d    = out_ack_q;
    a_done_d     = a_done_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          in1_d       = req_rs1_i;
          in2_d       = req_rs2_i;
          req_ready_d = 1'b0;
          if (req_op_i <= OP_LAST_FPU) begin
            state_d  = ISSUE;
            fpu_op_d = req_op_i;
            in_stb_d = 1'b1;
            a_done_d = 1'b0;
          end else if (req_op_i <= OP_FLE) begin
            state_d      = RESP;
            resp_data_d  = fcmp(req_op_i, req_rs1_i, req_rs2_i);
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
          end else begin
            state_d      = RESP;
            resp_data_d  = 32'd0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // in1 may be acked before in2; remember it until in2 arrives.
        a_done_d = a_done_q | fpu_in1_ack_i;
        if (fpu_in2_ack_i && (a_done_q || fpu_in1_ack_i)) begin
          state_d   = WAIT;
          in_stb_d  = 1'b0;
          out_ack_d = 1'b1;
          a_done_d  = 1'b0;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (fpu_out_stb_i) begin
          state_d      = RESP;
          resp_data_d  = fpu_out_i;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          out_ack_d    = 1'b0;
          fpu_op_d     = OP_NONE;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        fpu_op_d    = OP_NONE;
      end
      default: begin
        state_d     = IDLE;
        fpu_op_d    = OP_NONE;
        in_stb_d    = 1'b0;
        out_ack_d   = 1'b0;
        a_done_d    = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fpu_op_q     <= OP_NONE;
      in1_q        <= 32'd0;
      in2_q        <= 32'd0;
      in_stb_q     <= 1'b0;
      out_ack_q    <= 1'b0;
      a_done_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpu_op_q     <= fpu_op_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      in_stb_q     <= in_stb_d;
      out_ack_q    <= out_ack_d;
      a_done_q     <= a_done_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = resp_data_q;
  assign resp_err_o    = resp_err_q;
  assign fpu_op_o      = fpu_op_q;
  assign fpu_in1_o     = in1_q;
  assign fpu_in2_o     = in2_q;
  assign fpu_in_stb_o  = in_stb_q;
  assign fpu_out_ack_o = out_ack_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer. The bench plays the role of
// fpu_controller (acks and result strobes) and predicts every response.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic        fpu_in_stb;
  logic        fpu_in1_ack;
  logic        fpu_in2_ack;
  logic [31:0] fpu_out;
  logic        fpu_out_stb;
  logic        fpu_out_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_rs1_i     (req_rs1),
    .req_rs2_i     (req_rs2),
    .resp_valid_o  (resp_valid),
    .resp_data_o   (resp_data),
    .resp_err_o    (resp_err),
    .fpu_op_o      (fpu_op),
    .fpu_in1_o     (fpu_in1),
    .fpu_in2_o     (fpu_in2),
    .fpu_in_stb_o  (fpu_in_stb),
    .fpu_in1_ack_i (fpu_in1_ack),
    .fpu_in2_ack_i (fpu_in2_ack),
    .fpu_out_i     (fpu_out),
    .fpu_out_stb_i (fpu_out_stb),
    .fpu_out_ack_o (fpu_out_ack)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] fres;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference compare: map each float onto a signed integer number line
  // (magnitude, negated for negative sign) so ordinary integer compares apply.
  function automatic bit ref_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic longint ref_key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka;
    longint kb;
    if (ref_nan(a) || ref_nan(b)) return 32'd0;
    ka = ref_key(a);
    kb = ref_key(b);
    if (op == 4'd6) return (ka == kb) ? 32'd1 : 32'd0;
    if (op == 4'd7) return (ka <  kb) ? 32'd1 : 32'd0;
    return (ka <= kb) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   {31'd0, req_ready},   32'd1);
    check({tag, "_rvalid"},  {31'd0, resp_valid},  32'd0);
    check({tag, "_rdata"},   resp_data,            32'd0);
    check({tag, "_rerr"},    {31'd0, resp_err},    32'd0);
    check({tag, "_fpu_op"},  {28'd0, fpu_op},      32'hF);
    check({tag, "_in1"},     fpu_in1,              32'd0);
    check({tag, "_in2"},     fpu_in2,              32'd0);
    check({tag, "_in_stb"},  {31'd0, fpu_in_stb},  32'd0);
    check({tag, "_out_ack"}, {31'd0, fpu_out_ack}, 32'd0);
  endtask

  // One full transaction. ack_mode: 0 both acks together, 1 in1 then in2,
  // 2 lone in2 (must not advance) then in1 then in2.
  task automatic run_req(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] fres,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int ack_mode, input int out_delay);
    logic [1:0] seq [0:2];
    int         len;
    int         n;
    bit         seen1;
    bit         leave;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({name, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    step();
    req_valid = 1'b0;
    if (op <= 4'd5) begin
      check({name, "_issue_stb"}, {31'd0, fpu_in_stb}, 32'd1);
      check({name, "_issue_op"},  {28'd0, fpu_op},     {28'd0, op});
      check({name, "_issue_in1"}, fpu_in1,             a);
      check({name, "_issue_in2"}, fpu_in2,             b);
      check({name, "_issue_rdy"}, {31'd0, req_ready},  32'd0);
      case (ack_mode)
        1: begin seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b10; len = 3; end
        2: begin seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10; len = 3; end
        default: begin seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b00; len = 1; end
      endcase
      seen1 = 1'b0;
      for (int i = 0; i < len; i++) begin
        fpu_in1_ack = seq[i][0];
        fpu_in2_ack = seq[i][1];
        leave = seq[i][1] && (seen1 || seq[i][0]);
        seen1 = seen1 | seq[i][0];
        step();
        check({name, "_ack_stb"},    {31'd0, fpu_in_stb},  leave ? 32'd0 : 32'd1);
        check({name, "_ack_outack"}, {31'd0, fpu_out_ack}, leave ? 32'd1 : 32'd0);
      end
      fpu_in1_ack = 1'b0;
      fpu_in2_ack = 1'b0;
      for (int d = 0; d < out_delay; d++) begin
        step();
        check({name, "_wait_op"},     {28'd0, fpu_op},      {28'd0, op});
        check({name, "_wait_in1"},    fpu_in1,              a);
        check({name, "_wait_outack"}, {31'd0, fpu_out_ack}, 32'd1);
        check({name, "_wait_rvalid"}, {31'd0, resp_valid},  32'd0);
      end
      fpu_out     = fres;
      fpu_out_stb = 1'b1;
      step();
      fpu_out_stb = 1'b0;
      fpu_out     = $urandom;
    end else begin
      check({name, "_nofpu_op"},  {28'd0, fpu_op},     32'hF);
      check({name, "_nofpu_stb"}, {31'd0, fpu_in_stb}, 32'd0);
    end
    check({name, "_rvalid"}, {31'd0, resp_valid}, 32'd1);
    check({name, "_rdata"},  resp_data,           exp_data);
    check({name, "_rerr"},   {31'd0, resp_err},   {31'd0, exp_err});
    check({name, "_rready"}, {31'd0, req_ready},  32'd0);
    step();
    check({name, "_post_rvalid"}, {31'd0, resp_valid}, 32'd0);
    check({name, "_post_ready"},  {31'd0, req_ready},  32'd1);
    check({name, "_post_hold"},   resp_data,           exp_data);
    check({name, "_post_stb"},    {31'd0, fpu_in_stb}, 32'd0);
    check({name, "_post_op"},     {28'd0, fpu_op},     32'hF);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [0:7];
    specials[0] = 32'h00000000; specials[1] = 32'h80000000;
    specials[2] = 32'h7FC00000; specials[3] = 32'h7F800000;
    specials[4] = 32'hFF800000; specials[5] = 32'h3F800000;
    specials[6] = 32'hBF800000; specials[7] = 32'h7F800001;
    if ($urandom_range(0, 1) == 0) return specials[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  vec_t tbl [0:11];

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_f;
    logic [31:0] r_exp;
    logic        r_err;

    tbl[0]  = '{4'd0,  32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b0};
    tbl[1]  = '{4'd6,  32'h7FC00000, 32'h7FC00000, 32'd0, 32'd0, 1'b0};
    tbl[2]  = '{4'd6,  32'h80000000, 32'h00000000, 32'd0, 32'd1, 1'b0};
    tbl[3]  = '{4'd7,  32'h80000000, 32'h00000000, 32'd0, 32'd0, 1'b0};
    tbl[4]  = '{4'd8,  32'h80000000, 32'h00000000, 32'd0, 32'd1, 1'b0};
    tbl[5]  = '{4'd7,  32'hBF800000, 32'h40000000, 32'd0, 32'd1, 1'b0};
    tbl[6]  = '{4'd10, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b1};
    tbl[7]  = '{4'd7,  32'h40000000, 32'h3F800000, 32'd0, 32'd0, 1'b0};
    tbl[8]  = '{4'd8,  32'h3F800000, 32'h3F800000, 32'd0, 32'd1, 1'b0};
    tbl[9]  = '{4'd6,  32'h7F800000, 32'h7F800000, 32'd0, 32'd1, 1'b0};
    tbl[10] = '{4'd7,  32'hC0000000, 32'hBF800000, 32'd0, 32'd1, 1'b0};
    tbl[11] = '{4'd15, 32'h00000001, 32'h00000002, 32'd0, 32'd0, 1'b1};

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_op      = 4'd0;
    req_rs1     = 32'd0;
    req_rs2     = 32'd0;
    fpu_in1_ack = 1'b0;
    fpu_in2_ack = 1'b0;
    fpu_out     = 32'd0;
    fpu_out_stb = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;

    // Stray controller activity in IDLE must be ignored.
    fpu_in1_ack = 1'b1;
    fpu_in2_ack = 1'b1;
    fpu_out_stb = 1'b1;
    fpu_out     = 32'hDEADBEEF;
    step();
    fpu_in1_ack = 1'b0;
    fpu_in2_ack = 1'b0;
    fpu_out_stb = 1'b0;
    check_reset_vals("stray");

    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fres,
              tbl[i].exp_data, tbl[i].exp_err, i % 3, 2);
    end

    // Back-to-back: requester holds req_valid; second request waits for RESP.
    req_valid = 1'b1;
    req_op    = 4'd1;
    req_rs1   = 32'h40400000;
    req_rs2   = 32'h3F800000;
    step();
    check("b2b_first_op", {28'd0, fpu_op}, 32'h1);
    req_op    = 4'd4;
    req_rs1   = 32'd7;
    req_rs2   = 32'd0;
    fpu_in1_ack = 1'b1;
    fpu_in2_ack = 1'b1;
    step();
    fpu_in1_ack = 1'b0;
    fpu_in2_ack = 1'b0;
    check("b2b_wait_op",  {28'd0, fpu_op}, 32'h1);
    check("b2b_wait_in1", fpu_in1,         32'h40400000);
    fpu_out     = 32'h40000000;
    fpu_out_stb = 1'b1;
    step();
    fpu_out_stb = 1'b0;
    check("b2b_first_rvalid", {31'd0, resp_valid}, 32'd1);
    check("b2b_first_rdata",  resp_data,           32'h40000000);
    check("b2b_first_ready",  {31'd0, req_ready},  32'd0);
    step();
    check("b2b_idle_ready", {31'd0, req_ready},  32'd1);
    check("b2b_idle_op",    {28'd0, fpu_op},     32'hF);
    check("b2b_idle_stb",   {31'd0, fpu_in_stb}, 32'd0);
    step();
    req_valid = 1'b0;
    check("b2b_second_op",  {28'd0, fpu_op},     32'h4);
    check("b2b_second_in1", fpu_in1,             32'd7);
    check("b2b_second_stb", {31'd0, fpu_in_stb}, 32'd1);
    fpu_in1_ack = 1'b1;
    fpu_in2_ack = 1'b1;
    step();
    fpu_in1_ack = 1'b0;
    fpu_in2_ack = 1'b0;
    fpu_out     = 32'h40E00000;
    fpu_out_stb = 1'b1;
    step();
    fpu_out_stb = 1'b0;
    check("b2b_second_rvalid", {31'd0, resp_valid}, 32'd1);
    check("b2b_second_rdata",  resp_data,           32'h40E00000);
    step();

    // fdiv aborted by reset during WAIT: no response, reset values.
    req_valid = 1'b1;
    req_op    = 4'd3;
    req_rs1   = 32'h40E00000;
    req_rs2   = 32'h40000000;
    step();
    req_valid   = 1'b0;
    fpu_in1_ack = 1'b1;
    fpu_in2_ack = 1'b1;
    step();
    fpu_in1_ack = 1'b0;
    fpu_in2_ack = 1'b0;
    check("abort_in_wait", {31'd0, fpu_out_ack}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("abort");
    fpu_out     = 32'h40600000;
    fpu_out_stb = 1'b1;
    step();
    fpu_out_stb = 1'b0;
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    check("abort_no_data", resp_data,           32'd0);
    run_req("fmul", 4'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 1'b0, 1, 1);

    // Randomized requests against the reference model.
    for (int k = 0; k < 60; k++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = pick_operand();
      r_b  = pick_operand();
      r_f  = $urandom;
      if (r_op <= 4'd5) begin
        r_exp = r_f;
        r_err = 1'b0;
      end else if (r_op <= 4'd8) begin
        r_exp = ref_cmp(r_op, r_a, r_b);
        r_err = 1'b0;
      end else begin
        r_exp = 32'd0;
        r_err = 1'b1;
      end
      run_req($sformatf("rnd%0d_op%0d", k, r_op), r_op, r_a, r_b, r_f, r_exp, r_err,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
